// File: rtl/module_i2s_tx_pkg.sv
// Shared I2S frame geometry and the slot-bit selector used by the transmitter.
package module_i2s_tx_pkg;

  localparam int I2S_SLOT_BITS   = 32;
  localparam int I2S_FRAME_BITS  = 64;
  localparam int SAMPLE_WIDTH    = 18;
  localparam int I2S_DATA_OFFSET = 1;

  localparam int BIT_CNT_W  = $clog2(I2S_FRAME_BITS);
  localparam int SLOT_IDX_W = $clog2(I2S_SLOT_BITS);

  // Bit to drive at slot position k: MSB lands I2S_DATA_OFFSET BCLKs after the
  // word-select edge, and everything past the LSB is zero padding.
  function automatic logic slot_bit(input logic [SAMPLE_WIDTH-1:0] frame,
                                    input logic [SLOT_IDX_W-1:0]   k);
    logic [SLOT_IDX_W-1:0] idx;
    idx = SLOT_IDX_W'(SAMPLE_WIDTH - 1 + I2S_DATA_OFFSET) - k;
    if (k >= SLOT_IDX_W'(I2S_DATA_OFFSET) &&
        k <  SLOT_IDX_W'(SAMPLE_WIDTH + I2S_DATA_OFFSET)) begin
      return frame[idx];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/module_i2s_tx_fifo.sv
// Synchronous show-ahead sample FIFO; a push into a full FIFO succeeds only
// when a pop in the same cycle frees a slot.
module module_sample_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == LW'(DEPTH));
  assign empty_o = (level_o == '0);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q + LW'(do_push);
    rd_ptr_d = rd_ptr_q + LW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/module_i2s_tx.sv
// Mono-to-stereo I2S transmitter: buffers LPF samples, sends each as a left=right frame.
// Define I2S_TX_STATUS_EN to add sticky overflow/underflow flags with status_clr.
module module_i2s_tx
  import module_i2s_tx_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_in_rdy,
  input  logic [SAMPLE_WIDTH-1:0]     sample_in,
  output logic                        sample_req,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_sdata
`ifdef I2S_TX_STATUS_EN
  ,
  input  logic                        status_clr,
  output logic                        overflow,
  output logic                        underflow
`endif
);
  localparam int DW = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;

  logic [DW-1:0]           div_cnt_q, div_cnt_d;
  logic                    bclk_q, bclk_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic                    req_q, req_d;
  logic [SAMPLE_WIDTH-1:0] frame_q, frame_d;
  logic                    tc, fall, load;
  logic                    fifo_empty;
  logic [SAMPLE_WIDTH-1:0] fifo_rdata;
`ifdef I2S_TX_STATUS_EN
  logic                    fifo_full;
`endif

  module_sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (sample_in_rdy),
    .data_i  (sample_in),
    .pop_i   (load),
    .data_o  (fifo_rdata),
`ifdef I2S_TX_STATUS_EN
    .full_o  (fifo_full),
`else
    .full_o  (),
`endif
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // All serial outputs move only on BCLK falling events so the DAC sees
  // stable data at every BCLK rising edge.
  always_comb begin
    tc        = (div_cnt_q == DW'(BCLK_HALF_DIV - 1));
    fall      = tc & bclk_q;
    load      = fall & (bit_cnt_q == BIT_CNT_W'(I2S_FRAME_BITS - 1));
    div_cnt_d = tc ? '0 : div_cnt_q + DW'(1);
    bclk_d    = bclk_q ^ tc;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    frame_d   = frame_q;
    if (fall) begin
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      lrclk_d   = bit_cnt_d[BIT_CNT_W-1];
      sdata_d   = slot_bit(frame_q, bit_cnt_d[SLOT_IDX_W-1:0]);
    end
    // An empty FIFO at the frame boundary mutes the whole frame.
    if (load) begin
      frame_d = fifo_empty ? '0 : fifo_rdata;
    end
    req_d = load & ~fifo_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '1;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      req_q     <= 1'b0;
      frame_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      req_q     <= req_d;
      frame_q   <= frame_d;
    end
  end

  assign sample_req = req_q;
  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;

`ifdef I2S_TX_STATUS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;
  logic ovf_evt, udf_evt;

  // A new event in the same cycle as status_clr keeps its flag set.
  always_comb begin
    ovf_evt     = sample_in_rdy & fifo_full & ~(load & ~fifo_empty);
    udf_evt     = load & fifo_empty;
    overflow_d  = ovf_evt | (overflow_q & ~status_clr);
    underflow_d = udf_evt | (underflow_q & ~status_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_module_i2s_tx.sv
// Bench for module_i2s_tx: cycle-count based reference model, an I2S receiver, directed tests.
module tb_module_i2s_tx;
  localparam int H     = 8;
  localparam int DEPTH = 4;
  localparam int SW    = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample_in_rdy = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_req;
  logic [2:0]    fifo_level;
  logic          i2s_bclk, i2s_lrclk, i2s_sdata;
`ifdef I2S_TX_STATUS_EN
  logic          status_clr = 1'b0;
  logic          overflow, underflow;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  module_i2s_tx #(.BCLK_HALF_DIV(H), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_in_rdy (sample_in_rdy),
    .sample_in     (sample_in),
    .sample_req    (sample_req),
    .fifo_level    (fifo_level),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
`ifdef I2S_TX_STATUS_EN
    .status_clr    (status_clr),
    .overflow      (overflow),
    .underflow     (underflow),
`endif
    .i2s_sdata     (i2s_sdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: everything is derived from the number of clock edges
  // since reset release. BCLK level = (n/H)%2, falls at every n multiple of
  // 2H, fall j drives slot bit (j-1)%64, and bit 0 of a frame loads the sample.
  int            m_n = 0;
  logic [SW-1:0] m_q[$];
  logic [SW-1:0] m_frame = '0;
  logic          m_bclk = 0, m_lr = 0, m_sd = 0, m_req = 0;
  int            m_level = 0;
  logic          m_ovf = 0, m_udf = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_n = 0; m_q.delete(); m_frame = '0;
      m_bclk = 0; m_lr = 0; m_sd = 0; m_req = 0; m_level = 0; m_ovf = 0; m_udf = 0;
    end else begin
      int sz, j, b, k;
      bit popped, load;
      sz = m_q.size(); popped = 0; load = 0;
      m_n++;
      m_bclk = ((m_n / H) % 2) == 1;
      if (m_n % (2 * H) == 0) begin
        j = m_n / (2 * H);
        b = (j - 1) % 64;
        load = (b == 0);
        if (load) begin
          if (sz > 0) begin m_frame = m_q.pop_front(); popped = 1; end
          else m_frame = '0;
        end
        m_lr = (b >= 32);
        k = b % 32;
        m_sd = (k >= 1 && k <= SW) ? m_frame[SW-k] : 1'b0;
      end
      if (sample_in_rdy) begin
        if (sz < DEPTH || popped) m_q.push_back(sample_in);
`ifdef I2S_TX_STATUS_EN
        else m_ovf = 1'b1;
`endif
      end
`ifdef I2S_TX_STATUS_EN
      if (!(sample_in_rdy && sz == DEPTH && !popped) && status_clr) m_ovf = 1'b0;
      if (load && !popped) m_udf = 1'b1;
      else if (status_clr) m_udf = 1'b0;
`endif
      m_req = popped;
      m_level = m_q.size();
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    #1;
    if (reset === 1'b1) begin
      check("bclk",       32'(i2s_bclk),   32'(m_bclk));
      check("lrclk",      32'(i2s_lrclk),  32'(m_lr));
      check("sdata",      32'(i2s_sdata),  32'(m_sd));
      check("sample_req", 32'(sample_req), 32'(m_req));
      check("fifo_level", 32'(fifo_level), 32'(m_level));
`ifdef I2S_TX_STATUS_EN
      check("overflow",   32'(overflow),   32'(m_ovf));
      check("underflow",  32'(underflow),  32'(m_udf));
`endif
    end
  end

  // DAC-side receiver: samples on BCLK rising edges, slot position restarts at
  // each word-select edge; starts as if just past slot bit 62 (reset bit_cnt=63).
  logic [SW-1:0] rx_l[$], rx_r[$];
  int            rx_pos = 30;
  logic          rx_lr = 1'b0;
  logic [SW-1:0] rx_word = '0;
  int            rx_pad_ones = 0;

  initial forever begin
    @(posedge i2s_bclk or negedge reset);
    if (!reset) begin
      rx_pos = 30; rx_lr = 1'b0; rx_word = '0; rx_pad_ones = 0;
      rx_l.delete(); rx_r.delete();
    end else begin
      rx_pos = (i2s_lrclk != rx_lr) ? 0 : (rx_pos + 1) % 32;
      rx_lr  = i2s_lrclk;
      if (rx_pos >= 1 && rx_pos <= SW) rx_word = {rx_word[SW-2:0], i2s_sdata};
      else if (i2s_sdata) rx_pad_ones++;
      if (rx_pos == SW) begin
        if (rx_lr) rx_r.push_back(rx_word);
        else       rx_l.push_back(rx_word);
      end
    end
  end

  task automatic do_reset();
    sample_in_rdy = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic push(input logic [SW-1:0] v);
    sample_in = v;
    sample_in_rdy = 1'b1;
    @(negedge clk);
    sample_in_rdy = 1'b0;
  endtask

  task automatic wait_until_n(input int target);
    int lim;
    lim = 0;
    while (m_n < target && lim < 5000) begin @(negedge clk); lim++; end
    check("wait_n_reached", 32'(m_n >= target), 32'd1);
  endtask

  task automatic wait_words(input int nw, output int reqs);
    int lim;
    reqs = 0;
    lim = nw * 1100 + 400;
    while (rx_r.size() < nw && lim > 0) begin
      @(negedge clk);
      if (sample_req) reqs++;
      lim--;
    end
    check("frames_received", 32'(rx_r.size() >= nw), 32'd1);
  endtask

  task automatic measure_rise(input bit use_lr, output int per);
    int t0, c;
    logic prev, cur;
    t0 = -1; per = -1; c = 0;
    prev = use_lr ? i2s_lrclk : i2s_bclk;
    for (int lim = 0; lim < 3000 && per < 0; lim++) begin
      @(negedge clk);
      c++;
      cur = use_lr ? i2s_lrclk : i2s_bclk;
      if (cur && !prev) begin
        if (t0 >= 0) per = c - t0;
        else t0 = c;
      end
      prev = cur;
    end
  endtask

  initial begin
    int per, reqs;
    logic [SW-1:0] exp_v[5];

    // Idle after reset: clock periods, silent mute frames.
    do_reset();
    check("reset_level", 32'(fifo_level), 32'd0);
    check("reset_bclk",  32'(i2s_bclk),   32'd0);
    measure_rise(1'b0, per);
    check("bclk_period", 32'(per), 32'd16);
    measure_rise(1'b1, per);
    check("lrclk_period", 32'(per), 32'd1024);
    wait_words(2, reqs);
    check("idle_req_count", 32'(reqs), 32'd0);
    check("idle_left0",  32'(rx_l[0]), 32'd0);
    check("idle_right1", 32'(rx_r[1]), 32'd0);
    check("idle_pad",    32'(rx_pad_ones), 32'd0);
`ifdef I2S_TX_STATUS_EN
    check("idle_underflow", 32'(underflow), 32'd1);
`endif

    // Single alternating sample, duplicated into both slots, then mute.
    do_reset();
    push(18'h2AAAA);
    wait_words(2, reqs);
    check("alt_req_count", 32'(reqs), 32'd1);
    check("alt_left0",  32'(rx_l[0]), 32'h2AAAA);
    check("alt_right0", 32'(rx_r[0]), 32'h2AAAA);
    check("alt_left1",  32'(rx_l[1]), 32'd0);
    check("alt_pad",    32'(rx_pad_ones), 32'd0);

    // Five back-to-back pushes: fifth dropped, four frames then mute.
    do_reset();
    for (int i = 1; i <= 5; i++) push(SW'(i));
    check("burst_level", 32'(fifo_level), 32'd4);
`ifdef I2S_TX_STATUS_EN
    check("burst_overflow", 32'(overflow), 32'd1);
`endif
    wait_words(5, reqs);
    check("burst_req_count", 32'(reqs), 32'd4);
    for (int i = 0; i < 4; i++) check("burst_left", 32'(rx_l[i]), 32'(i + 1));
    check("burst_right3", 32'(rx_r[3]), 32'd4);
    check("burst_mute4",  32'(rx_l[4]), 32'd0);

    // Full FIFO with a push landing on the frame-load pop.
    do_reset();
    for (int i = 0; i < 4; i++) push(SW'(18'h3F000 + i));
    wait_until_n(15);
    push(18'h3F004);
    check("popush_level", 32'(fifo_level), 32'd4);
    check("popush_req",   32'(sample_req), 32'd1);
    wait_words(5, reqs);
    for (int i = 0; i < 5; i++) exp_v[i] = SW'(18'h3F000 + i);
    for (int i = 0; i < 5; i++) check("popush_left", 32'(rx_l[i]), 32'(exp_v[i]));

    // Asynchronous reset mid-frame (bit_cnt=20) with two samples queued.
    do_reset();
    push(18'h00111); push(18'h00222); push(18'h00333);
    wait_until_n(344);
    @(posedge clk);
    #2;
    check("pre_reset_level", 32'(fifo_level), 32'd2);
    check("pre_reset_bclk",  32'(i2s_bclk),   32'd1);
    reset = 1'b0;
    #1;
    check("async_bclk",  32'(i2s_bclk),   32'd0);
    check("async_lrclk", 32'(i2s_lrclk),  32'd0);
    check("async_sdata", 32'(i2s_sdata),  32'd0);
    check("async_req",   32'(sample_req), 32'd0);
    check("async_level", 32'(fifo_level), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_level", 32'(fifo_level), 32'd0);
    wait_words(1, reqs);
    check("post_reset_req",  32'(reqs), 32'd0);
    check("post_reset_mute", 32'(rx_l[0]), 32'd0);

`ifdef I2S_TX_STATUS_EN
    // Clear alone drops the flag; clear on an underflow cycle loses to the set.
    do_reset();
    wait_until_n(16);
    check("udf_set", 32'(underflow), 32'd1);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    check("udf_cleared", 32'(underflow), 32'd0);
    wait_until_n(1039);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    check("udf_set_wins", 32'(underflow), 32'd1);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
